// File: rtl/div_pkg.sv
// Shared state encoding and sizing helpers for the sequential non-restoring divider.
package div_pkg;

  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CORR,
    DONE
  } state_t;

  // Iteration counter must hold the value W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring iteration: shift {P,Q} left, then add or subtract |divisor|.
module div_nr_step #(
  parameter int W = 4
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] q_next
);

  logic [W:0] p_sh;

  always_comb begin
    p_sh   = {p[W-1:0], q[W-1]};
    // The sign of the old partial remainder picks the operation, not the shifted value.
    p_next = p[W] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
    q_next = {q[W-2:0], ~p_next[W]};
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider, 2W-bit dividend by W-bit divisor.
// Signed two's-complement operation is enabled by defining DIV_SIGNED_EN; otherwise unsigned.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(W);

  state_t         state, state_next;
  logic [W:0]     p, p_step;
  logic [W-1:0]   q, q_step;
  logic [W-1:0]   d_mag;
  logic [CW-1:0]  count;
  logic [2*W-1:0] dvd_mag;
  logic [W-1:0]   dvs_mag;
  logic           err_zero, err_range;
  logic [W-1:0]   rem_mag, quot_res, rem_res;
  logic           ovf_res;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] NEG_LIMIT = {1'b1, {(W-1){1'b0}}};
  logic q_neg, r_neg;

  always_comb begin
    dvd_mag = dividend[2*W-1] ? -dividend : dividend;
    dvs_mag = divisor[W-1] ? -divisor : divisor;
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
  end
`endif

  always_comb begin
    err_zero  = (divisor == '0);
    err_range = (dvd_mag[2*W-1:W] >= dvs_mag);
  end

  div_nr_step #(.W(W)) u_step (
    .p      (p),
    .q      (q),
    .d      (d_mag),
    .p_next (p_step),
    .q_next (q_step)
  );

  // Final correction: restore a negative remainder, then range-check and apply signs.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    rem_mag  = p[W] ? p[W-1:0] + d_mag : p[W-1:0];
    quot_res = q;
    rem_res  = rem_mag;
    ovf_res  = 1'b0;
`ifdef DIV_SIGNED_EN
    ovf_res = q_neg ? (q > NEG_LIMIT) : q[W-1];
    if (q_neg) quot_res = -q;
    if (r_neg) rem_res = -rem_mag;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (err_zero || err_range) ? DONE : CALC;
      CALC:    if (count == CW'(1)) state_next = CORR;
      CORR:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset too, so an aborted operation leaves no stale state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p           <= '0;
      q           <= '0;
      d_mag       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          d_mag       <= dvs_mag;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          busy        <= 1'b1;
`ifdef DIV_SIGNED_EN
          q_neg       <= dividend[2*W-1] ^ divisor[W-1];
          r_neg       <= dividend[2*W-1];
`endif
          if (err_zero) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend[W-1:0];
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (err_range) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            p     <= {1'b0, dvd_mag[2*W-1:W]};
            q     <= dvd_mag[W-1:0];
            count <= CW'(W);
          end
        end
        CALC: begin
          p     <= p_step;
          q     <= q_step;
          count <= count - CW'(1);
        end
        CORR: begin
          overflow  <= ovf_res;
          quotient  <= ovf_res ? '0 : quot_res;
          remainder <= ovf_res ? '0 : rem_res;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider (W=4); expectations follow DIV_SIGNED_EN as built.
module tb_nonrestoring_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [7:0]  a;
    logic [3:0]  b;
    logic [10:0] exp;   // {busy, div_by_zero, overflow, quotient, remainder}
    logic [7:0]  lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nonrestoring_divider #(.W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Issues one division from IDLE and reports outputs seen in the done cycle;
  // lat counts edges from accept to done, -1 if done never arrives.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output logic [10:0] obs, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    obs = {busy, div_by_zero, overflow, quotient, remainder};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %h want 000",
               {busy, done, div_by_zero, overflow, quotient, remainder});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: got %h want 000",
               {busy, done, div_by_zero, overflow, quotient, remainder});
    end
  endtask

  task automatic test_basic();
    logic [10:0] obs;
    int          lat;
    run_div(8'h17, 4'h5, obs, lat);
    checks++;
    if (obs !== {3'b000, 4'h4, 4'h3}) begin
      errors++;
      $display("FAIL basic_23_5: got %h want %h", obs, {3'b000, 4'h4, 4'h3});
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 6", lat);
    end
  endtask

  task automatic test_signs();
    vec_t        tbl [4];
    logic [10:0] obs;
    int          lat;
`ifdef DIV_SIGNED_EN
    tbl[0] = '{8'hE9, 4'h5, {3'b000, 4'hC, 4'hD}, 8'd6};  // -23 / 5
    tbl[1] = '{8'h17, 4'hB, {3'b000, 4'hC, 4'h3}, 8'd6};  //  23 / -5
    tbl[2] = '{8'hE9, 4'hB, {3'b000, 4'h4, 4'hD}, 8'd6};  // -23 / -5
    tbl[3] = '{8'h07, 4'h8, {3'b000, 4'h0, 4'h7}, 8'd6};  //   7 / -8
`else
    tbl[0] = '{8'h17, 4'hB, {3'b000, 4'h2, 4'h1}, 8'd6};  //  23 / 11
    tbl[1] = '{8'h9F, 4'hC, {3'b000, 4'hD, 4'h3}, 8'd6};  // 159 / 12
    tbl[2] = '{8'h2D, 4'hF, {3'b000, 4'h3, 4'h0}, 8'd6};  //  45 / 15
    tbl[3] = '{8'h7F, 4'h8, {3'b000, 4'hF, 4'h7}, 8'd6};  // 127 / 8, largest quotient
`endif
    for (int i = 0; i < 4; i++) begin
      run_div(tbl[i].a, tbl[i].b, obs, lat);
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("FAIL signs[%0d] %h/%h: got %h want %h", i, tbl[i].a, tbl[i].b, obs, tbl[i].exp);
      end
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        errors++;
        $display("FAIL signs_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [10:0] obs;
    int          lat;
    run_div(8'h17, 4'h0, obs, lat);
    checks++;
    if (obs !== {3'b010, 4'hF, 4'h7}) begin
      errors++;
      $display("FAIL div_zero: got %h want %h", obs, {3'b010, 4'hF, 4'h7});
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d want 1", lat);
    end
  endtask

  task automatic test_overflow();
    vec_t        tbl [4];
    logic [10:0] obs;
    int          lat;
    tbl[0] = '{8'h40, 4'h2, {3'b001, 4'h0, 4'h0}, 8'd1};      // 64 / 2, caught at accept
`ifdef DIV_SIGNED_EN
    tbl[1] = '{8'h10, 4'h2, {3'b001, 4'h0, 4'h0}, 8'd6};      // 16 / 2 = 8, too big
    tbl[2] = '{8'hF0, 4'h2, {3'b000, 4'h8, 4'h0}, 8'd6};      // -16 / 2 = -8, fits
    tbl[3] = '{8'hEE, 4'h2, {3'b001, 4'h0, 4'h0}, 8'd6};      // -18 / 2 = -9, too big
`else
    tbl[1] = '{8'h10, 4'h2, {3'b000, 4'h8, 4'h0}, 8'd6};      // 16 / 2 = 8 unsigned
    tbl[2] = '{8'hF0, 4'h2, {3'b001, 4'h0, 4'h0}, 8'd1};      // 240 / 2, caught at accept
    tbl[3] = '{8'hEE, 4'h2, {3'b001, 4'h0, 4'h0}, 8'd1};      // 238 / 2, caught at accept
`endif
    for (int i = 0; i < 4; i++) begin
      run_div(tbl[i].a, tbl[i].b, obs, lat);
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("FAIL overflow[%0d] %h/%h: got %h want %h", i, tbl[i].a, tbl[i].b, obs, tbl[i].exp);
      end
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        errors++;
        $display("FAIL overflow_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    int          lat;
    int          pulses;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'h17;
    divisor  = 4'h5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_calc: got %b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 000",
               {busy, done, div_by_zero, overflow, quotient, remainder});
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses);
    end
    run_div(8'h17, 4'h5, obs, lat);
    checks++;
    if (obs !== {3'b000, 4'h4, 4'h3} || lat != 6) begin
      errors++;
      $display("FAIL reset_mid_rerun: got %h lat %0d want %h lat 6", obs, lat, {3'b000, 4'h4, 4'h3});
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] obs;
    int          pulses;
    obs = '0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'h17;
    divisor  = 4'h5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'h2D;
    divisor  = 4'h7;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        obs = {busy, div_by_zero, overflow, quotient, remainder};
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL start_ignored_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (obs !== {3'b000, 4'h4, 4'h3}) begin
      errors++;
      $display("FAIL start_ignored_result: got %h want %h", obs, {3'b000, 4'h4, 4'h3});
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs_a, obs_b;
    int          lat_a, lat_b;
    run_div(8'h17, 4'h5, obs_a, lat_a);
    run_div(8'h2D, 4'h7, obs_b, lat_b);   // 45 / 7 = 6 r 3
    checks++;
    if (obs_a !== {3'b000, 4'h4, 4'h3} || lat_a != 6) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat 6", obs_a, lat_a, {3'b000, 4'h4, 4'h3});
    end
    checks++;
    if (obs_b !== {3'b000, 4'h6, 4'h3} || lat_b != 6) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat 6", obs_b, lat_b, {3'b000, 4'h6, 4'h3});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
